// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline control bus between the pipeline stages and the stall/flush sequencer.
// The master side raises stall requests and exceptions. The slave side (the sequencer)
// returns the stall vector, the flush/redirect and the divider control.
interface pipe_stall_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        div_start;
  logic        div_done;
  logic        stallreq_mem;
  logic        except_valid;
  logic [31:0] except_type;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        div_cancel;
  logic        div_timeout;
  logic [31:0] stall_cycles;

  modport master (
    output stallreq_if, stallreq_id, div_start, div_done, stallreq_mem,
           except_valid, except_type, cp0_epc,
    input  stall, flush, new_pc, div_cancel, div_timeout, stall_cycles
  );

  modport slave (
    input  stallreq_if, stallreq_id, div_start, div_done, stallreq_mem,
           except_valid, except_type, cp0_epc,
    output stall, flush, new_pc, div_cancel, div_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline sequencer for the 5-stage MIPS core.
// It merges the per-stage stall requests into the 6-bit stall vector and runs the divider wait.
// It also turns an accepted MEM-stage exception into EXC (frozen) and then FLUSH (one flush pulse).
module pipe_stall_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int          DIV_MAX    = 40
) (
  input logic              clk,
  input logic              reset,
  pipe_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN,
    DIV,
    EXC,
    FLUSH
  } state_t;

  localparam logic [31:0] DIV_LIMIT = 32'(DIV_MAX);
  localparam logic [31:0] ERET_CODE = 32'hE;

  state_t      state;
  logic [5:0]  stall_c;
  logic        flush_r;
  logic [31:0] new_pc_r;
  logic        div_cancel_r;
  logic        div_timeout_r;
  logic [31:0] stall_cycles_r;
  logic [31:0] div_count;
  logic        exc_take;
  logic [31:0] exc_target;

  // An exception on a MEM instruction that is still waiting for data is held until the access completes
  assign exc_take   = bus.except_valid && !bus.stallreq_mem;
  assign exc_target = (bus.except_type == ERET_CODE) ? bus.cp0_epc : EXC_VECTOR;

  // Merge the stall requests: the later pipeline stage dominates, and EXC/FLUSH override everything
  always_comb begin
    stall_c = 6'b000000;
    if (state == EXC)
      stall_c = 6'b011111;
    else if (state == FLUSH)
      stall_c = 6'b000000;
    else if (bus.stallreq_mem)
      stall_c = 6'b011111;
    else if (state == DIV && !bus.div_done)
      stall_c = 6'b001111;
    else if (state == RUN && bus.div_start)
      stall_c = 6'b001111;
    else if (bus.stallreq_id)
      stall_c = 6'b000111;
    else if (bus.stallreq_if)
      stall_c = 6'b000011;
  end

  // Sequencer FSM with registered flush/redirect/cancel outputs, divider watchdog and stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RUN;
      flush_r        <= 1'b0;
      new_pc_r       <= 32'h0;
      div_cancel_r   <= 1'b0;
      div_timeout_r  <= 1'b0;
      stall_cycles_r <= 32'h0;
      div_count      <= 32'h0;
    end else begin
      flush_r      <= 1'b0;
      div_cancel_r <= 1'b0;
      if (stall_c != 6'b000000)
        stall_cycles_r <= stall_cycles_r + 32'd1;
      case (state)
        RUN: begin
          if (exc_take) begin
            state        <= EXC;
            new_pc_r     <= exc_target;
            div_cancel_r <= bus.div_start;
          end else if (bus.div_start) begin
            state     <= DIV;
            div_count <= 32'h0;
          end
        end
        DIV: begin
          if (exc_take) begin
            state        <= EXC;
            new_pc_r     <= exc_target;
            div_cancel_r <= 1'b1;
          end else if (bus.div_done) begin
            state <= RUN;
          end
          if (div_count < DIV_LIMIT)
            div_count <= div_count + 32'd1;
          if (div_count + 32'd1 >= DIV_LIMIT)
            div_timeout_r <= 1'b1;
        end
        EXC: begin
          state   <= FLUSH;
          flush_r <= 1'b1;
        end
        FLUSH: begin
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.stall        = stall_c;
  assign bus.flush        = flush_r;
  assign bus.new_pc       = new_pc_r;
  assign bus.div_cancel   = div_cancel_r;
  assign bus.div_timeout  = div_timeout_r;
  assign bus.stall_cycles = stall_cycles_r;

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage MIPS core.
- Merges per-stage stall requests into the 6-bit stall vector consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Runs the multi-cycle divider wait sequence.
- Turns MEM-stage exceptions into a registered flush pulse plus a redirect PC.

Parameters:
- EXC_VECTOR, 32'hBFC00380, general exception entry PC.
- DIV_MAX, 40, maximum divider busy cycles before the timeout flag is set.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- stallreq_if  in  1  fetch not ready (icache/bus wait).
- stallreq_id  in  1  load-use hazard in decode.
- div_start  in  1  EX issues divide this cycle (1-cycle pulse).
- div_done  in  1  divider result valid (1-cycle pulse).
- stallreq_mem  in  1  data access not complete.
- except_valid  in  1  exception detected on the instruction in MEM.
- except_type  in  32  cause code; 32'h1 = interrupt, 32'hE = eret, anything else = synchronous exception.
- cp0_epc  in  32  current EPC.
- stall  out  6  [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB; 1 = Stop.
- flush  out  1  clear all pipeline registers.
- new_pc  out  32  redirect target, valid while flush = 1.
- div_cancel  out  1  abort the running divide.
- div_timeout  out  1  sticky error flag.
- stall_cycles  out  32  count of cycles with stall != 0; wraps.

Behaviour:
- States:
  - RUN: normal operation.
  - DIV: divider busy.
  - EXC: exception accepted, pipeline frozen.
  - FLUSH: flush pulse.
- Reset: state = RUN, stall = 0, flush = 0, new_pc = 0, div_cancel = 0, div_timeout = 0, stall_cycles = 0, div counter = 0. Reset takes effect in any state, including mid-divide.
- stall is combinational from the current state and requests. flush, new_pc and div_cancel are registered.
- Stall priority (highest first):
  - state EXC: 6'b011111.
  - state FLUSH: 6'b000000.
  - stallreq_mem: 6'b011111.
  - DIV && !div_done: 6'b001111.
  - RUN && div_start: 6'b001111.
  - stallreq_id: 6'b000111.
  - stallreq_if: 6'b000011.
  - otherwise 6'b000000.
- A request on a later stage dominates, so a simultaneous id and mem request gives 011111.
- RUN transitions:
  - except_valid && !stallreq_mem → EXC. new_pc is latched at this edge: cp0_epc if except_type == 32'hE, otherwise EXC_VECTOR.
  - Else div_start → DIV, div counter cleared.
  - An exception and div_start in the same cycle: the exception wins (it belongs to the older instruction), and div_cancel pulses in the next cycle.
- Exception gating: except_valid is ignored while stallreq_mem = 1. The MEM instruction is held, and the exception is taken in the first cycle that stallreq_mem = 0.
- DIV transitions:
  - Counter increments each cycle.
  - div_done → RUN. The stall deasserts combinationally in the div_done cycle, so there are 0 extra bubbles.
  - except_valid && !stallreq_mem → EXC, with div_cancel = 1 for exactly one cycle (registered).
  - Counter reaching DIV_MAX sets div_timeout, which stays set until reset. The state remains DIV.
- EXC → FLUSH unconditionally, after 1 cycle.
- FLUSH: flush = 1 for exactly one cycle with new_pc held, then → RUN. All requests are ignored in EXC and FLUSH.
- Exception latency: except_valid sampled at edge N → flush high during cycle N+1 → RUN at N+2.
- stall_cycles increments on every edge where stall != 0, wrapping 32'hFFFFFFFF → 0.

Test Plan:
- Reset then idle, all requests 0 → stall = 0, flush = 0, stall_cycles stays 0. Reset asserted while in DIV → state RUN, stall = 0 next cycle.
- stallreq_id = 1 for 2 cycles together with stallreq_if = 1 → stall = 6'b000111 for both cycles; stall_cycles = 2.
- div_start, then div_done 8 cycles later → stall = 6'b001111 for 8 cycles, 000000 in the div_done cycle; div_timeout = 0. Repeat with div_done at 45 cycles (DIV_MAX = 40) → div_timeout = 1 and remains 1.
- except_valid with except_type = 32'h4 while stallreq_mem = 1 for 3 cycles → no flush during those cycles; one cycle after mem releases stall = 6'b011111, then flush = 1 for 1 cycle with new_pc = 32'hBFC00380.
- eret (except_type = 32'hE, cp0_epc = 32'h80001234) in RUN → flush pulse with new_pc = 32'h80001234, stall = 0 during flush.
- Exception during DIV → div_cancel high exactly 1 cycle, flush the following cycle, state returns to RUN; a later div_done is ignored.
